// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART TX write port among N_REQ sources
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DBIT    = 8,
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DBIT-1:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [DBIT-1:0]       w_data,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic                  len_err,
    output logic                  timeout_err
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [7:0]      byte_cnt;
    logic [15:0]     stall_cnt;
    logic [PW-1:0]   pick;
    logic            pick_ok;
    logic            owner_valid;
    logic            owner_last;
    logic            xfer;
    logic [PW-1:0]   next_ptr;
    int              idx;

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!pick_ok && req_valid[idx]) begin
                pick_ok = 1'b1;
                pick    = PW'(idx);
            end
        end
    end

    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign xfer        = (state == SEND) && owner_valid && !tx_full;
    assign wr_uart     = xfer;
    assign w_data      = (state == SEND) ? req_data[int'(owner)*DBIT +: DBIT] : '0;
    assign next_ptr    = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state == SEND) begin
            req_ready[owner] = !tx_full;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            byte_cnt    <= '0;
            stall_cnt   <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        state       <= SEND;
                        owner       <= pick;
                        byte_cnt    <= '0;
                        stall_cnt   <= '0;
                        grant       <= '0;
                        grant[pick] <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        byte_cnt  <= byte_cnt + 8'd1;
                        stall_cnt <= '0;
                        if (owner_last || byte_cnt == 8'(MAX_LEN - 1)) begin
                            state   <= IDLE;
                            grant   <= '0;
                            busy    <= 1'b0;
                            ptr     <= next_ptr;
                            len_err <= !owner_last;
                        end
                    end else if (!owner_valid) begin
                        // Only an absent source ages the grant; tx_full backpressure does not.
                        stall_cnt <= stall_cnt + 16'd1;
                        if (stall_cnt == 16'(TIMEOUT - 1)) begin
                            state       <= IDLE;
                            grant       <= '0;
                            busy        <= 1'b0;
                            ptr         <= next_ptr;
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DB = 8;
    localparam int ML = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_last, req_ready, grant;
    logic [N*DB-1:0] req_data;
    logic            tx_full, wr_uart, busy, len_err, timeout_err;
    logic [DB-1:0]   w_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DBIT(DB), .MAX_LEN(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .busy(busy),
        .len_err(len_err), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = idle), next scan start, bytes sent, idle cycles.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_sent  = 0;
    int   m_idle  = 0;
    bit   m_len   = 1'b0;
    bit   m_to    = 1'b0;
    int   acc     = -1;
    logic o_wr;
    logic [DB-1:0] o_wd;

    int src_pend [N];
    int src_wait [N];
    logic [DB-1:0] src_byte [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks mid-cycle, advances the model, returns at next posedge+1.
    task automatic tick();
        logic [N-1:0] e_grant, e_ready;
        logic         e_wr;
        bit           found;
        #4;
        e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_ready = (m_owner >= 0 && !tx_full) ? N'(1 << m_owner) : '0;
        e_wr    = (m_owner >= 0) && req_valid[m_owner] && !tx_full;
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("len_err", 32'(len_err), 32'(m_len));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("wr_uart", 32'(wr_uart), 32'(e_wr));
        if (m_owner < 0)
            chk("w_data_idle", 32'(w_data), 32'h0);
        else if (e_wr)
            chk("w_data", 32'(w_data), 32'(req_data[m_owner*DB +: DB]));
        o_wr = wr_uart;
        o_wd = w_data;
        acc  = e_wr ? m_owner : -1;
        m_len = 1'b0;
        m_to  = 1'b0;
        if (!reset) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(m_ptr + k) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % N;
                    m_sent  = 0;
                    m_idle  = 0;
                end
            end
        end else if (e_wr) begin
            m_sent++;
            m_idle = 0;
            if (req_last[m_owner] || m_sent == ML) begin
                m_len   = !req_last[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else if (!req_valid[m_owner]) begin
            m_idle++;
            if (m_idle == TO) begin
                m_to    = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [DB-1:0] d, input logic l);
        req_valid[i]        = 1'b1;
        req_data[i*DB +: DB] = d;
        req_last[i]         = l;
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_full = 1'b0;
        @(posedge clk);
        #1;
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_wdata", 32'(o_wd), 32'h0);
        reset = 1'b1;

        // single packet from source 2, then ptr must point at 3
        set_src(2, 8'h41, 1'b0);
        tick();
        chk("sp_grant", 32'(grant), 32'h4);
        for (int b = 0; b < 3; b++) begin
            set_src(2, 8'(8'h41 + b), b == 2);
            tick();
            chk("sp_wr", 32'(o_wr), 32'h1);
            chk("sp_wdata", 32'(o_wd), 32'(8'h41 + b));
        end
        chk("sp_idle", 32'(grant), 32'h0);
        for (int i = 0; i < N; i++) set_src(i, 8'(8'h10 + i), 1'b1);
        tick();
        chk("sp_ptr", 32'(grant), 32'h8);
        tick();

        // round robin from reset with single-byte packets
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(1 << (n % 4)));
            tick();
            chk("rr_gap", 32'(busy), 32'h0);
        end

        // backpressure longer than TIMEOUT must not revoke
        req_valid = '0;
        set_src(1, 8'hA0, 1'b0);
        tick(); tick();
        set_src(1, 8'hA1, 1'b0);
        tx_full = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("bp_wr", 32'(o_wr), 32'h0);
        end
        chk("bp_busy", 32'(busy), 32'h1);
        chk("bp_to", 32'(timeout_err), 32'h0);
        tx_full = 1'b0;
        tick();
        chk("bp_resume", 32'(o_wd), 32'hA1);
        set_src(1, 8'hA2, 1'b1);
        tick();
        req_valid = '0;

        // length cap, then grant moves on to source 1
        set_src(0, 8'hC0, 1'b0);
        tick();
        set_src(1, 8'hD0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_src(0, 8'(8'hC0 + b), 1'b0);
            tick();
            chk("cap_wr", 32'(o_wr), 32'h1);
        end
        chk("cap_len", 32'(len_err), 32'h1);
        chk("cap_grant", 32'(grant), 32'h0);
        tick();
        chk("cap_next", 32'(grant), 32'h2);
        tick();
        chk("cap_pulse", 32'(len_err), 32'h0);
        req_valid = '0;

        // timeout after TO idle cycles
        set_src(1, 8'hE0, 1'b0);
        tick(); tick();
        req_valid = '0;
        for (int n = 0; n < TO - 1; n++) tick();
        chk("to_hold", 32'(busy), 32'h1);
        tick();
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
        tick();
        chk("to_pulse", 32'(timeout_err), 32'h0);

        // reset in the middle of a packet
        set_src(0, 8'hF0, 1'b0);
        tick(); tick();
        set_src(0, 8'hF1, 1'b0);
        reset = 1'b0;
        tick();
        chk("rmp_grant", 32'(grant), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_src(i, 8'(8'h20 + i), 1'b1);
        tick();
        chk("rmp_wr", 32'(o_wr), 32'h0);
        chk("rmp_restart", 32'(grant), 32'h1);
        tick();
        req_valid = '0;
        tick();

        // randomized traffic: random packet lengths, gaps, long stalls, backpressure, resets
        for (int i = 0; i < N; i++) begin
            src_pend[i] = 0;
            src_wait[i] = $urandom_range(0, 3);
            src_byte[i] = 8'($urandom);
        end
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_pend[i] == 0 && src_wait[i] == 0) begin
                    src_pend[i] = $urandom_range(1, 6);
                    src_byte[i] = 8'($urandom);
                end
                req_valid[i] = (src_pend[i] > 0 && src_wait[i] == 0);
                req_data[i*DB +: DB] = src_byte[i];
                req_last[i] = (src_pend[i] == 1);
            end
            tx_full = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 299) != 0);
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc == i) begin
                    int r;
                    src_pend[i]--;
                    src_byte[i] = 8'($urandom);
                    r = $urandom_range(0, 99);
                    if (src_pend[i] == 0) src_wait[i] = $urandom_range(0, 5);
                    else src_wait[i] = (r < 80) ? 0 : (r < 94) ? $urandom_range(1, 3) : TO + 2;
                end else if (!req_valid[i] && src_wait[i] > 0) begin
                    src_wait[i]--;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
